// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, datapath mux
// selects, FSM states and the per-state control word decoded from the state.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_BRANCH,
    S_JUMP, S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_HALT, S_ILLEGAL
  } state_e;

  // fetch marks FETCH so the top can gate ir_write/pc_write with mem_ready.
  typedef struct packed {
    logic       pc_write;
    logic       fetch;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch     = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH;
        c.alu_op    = ALUOP_ADD;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_WB_R: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_WB_I: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_RT;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_WB_MEM: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_HALT:    c.halted  = 1'b1;
      S_ILLEGAL: c.illegal = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: wraps modulo 2^CNT_W, cleared by rst_n.
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    if (inc) count_d = count_q + CNT_W'(1);
    else     count_d = count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle Moore control unit: sequences fetch/decode/execute/memory/writeback,
// waits on mem_ready in memory states, traps on halt/illegal, counts retirements.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int OPCODE_W     = 6,
  parameter int CNT_W        = 32,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic                halted,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   retire_d;

  // retire_d flags the edge that leaves the last state of an instruction.
  always_comb begin
    state_d  = state_q;
    retire_d = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OPCODE_W'(OP_RTYPE):                     state_d = S_EXEC_R;
          OPCODE_W'(OP_ADDI), OPCODE_W'(OP_ADDIU): state_d = S_EXEC_I;
          OPCODE_W'(OP_BEQ):                       state_d = S_BRANCH;
          OPCODE_W'(OP_J):                         state_d = S_JUMP;
          OPCODE_W'(OP_LW), OPCODE_W'(OP_SW):      state_d = S_MEM_ADDR;
          OPCODE_W'(OP_HLT):                       state_d = S_HALT;
          default: begin
            if (TRAP_ILLEGAL) begin
              state_d = S_ILLEGAL;
            end else begin
              state_d  = S_FETCH;
              retire_d = 1'b1;
            end
          end
        endcase
      end
      S_EXEC_R: state_d = S_WB_R;
      S_EXEC_I: state_d = S_WB_I;
      S_WB_R, S_WB_I, S_BRANCH, S_JUMP, S_WB_MEM: begin
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
      S_MEM_ADDR: begin
        if (opcode == OPCODE_W'(OP_SW)) state_d = S_MEM_WR;
        else                            state_d = S_MEM_RD;
      end
      S_MEM_RD: begin
        if (mem_ready) state_d = S_WB_MEM;
        else           state_d = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d  = S_FETCH;
          retire_d = 1'b1;
        end else begin
          state_d = S_MEM_WR;
        end
      end
      S_HALT:    state_d = S_HALT;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_IDLE;
    endcase
  end

  // Control word is registered alongside the state so it tracks state_q exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
    end
  end

  retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire_d),
    .count (retired)
  );

  assign pc_write      = ctrl_q.pc_write | (ctrl_q.fetch & mem_ready);
  assign ir_write      = ctrl_q.fetch & mem_ready;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign iord          = ctrl_q.iord;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_dst       = ctrl_q.reg_dst;
  assign reg_write     = ctrl_q.reg_write;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_op        = ctrl_q.alu_op;
  assign pc_source     = ctrl_q.pc_source;
  assign halted        = ctrl_q.halted;
  assign illegal       = ctrl_q.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control words are
// queued as stimulus is driven and compared on the falling edge.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic mem_ready = 1'b0;
  logic sel2 = 1'b0;

  logic pcw1, pcc1, iord1, mrd1, mwr1, irw1, m2r1, rdst1, rw1, sa1, hlt1, ill1;
  logic [1:0] sb1, aop1, ps1;
  logic [31:0] retired;
  logic pcw2, pcc2, iord2, mrd2, mwr2, irw2, m2r2, rdst2, rw2, sa2, hlt2, ill2;
  logic [1:0] sb2, aop2, ps2;
  logic [3:0] retired2;

  int n_chk = 0;
  int n_err = 0;
  int exp_ret = 0;
  logic [17:0] exp_q[$];
  string tag_q[$];

  // bit order: pcw pcc iord mrd mwr irw m2r rdst rw sa sb[2] aop[2] ps[2] hlt ill
  localparam logic [17:0] E_IDLE    = 18'b0;
  localparam logic [17:0] E_FETCH   = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_FETCH_W = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_DECODE  = {10'b0,2'b11,2'b00,2'b00,2'b00};
  localparam logic [17:0] E_EXEC_R  = {9'b0,1'b1,2'b00,2'b10,2'b00,2'b00};
  localparam logic [17:0] E_WB_R    = {7'b0,1'b1,1'b1,1'b0,8'b0};
  localparam logic [17:0] E_EXEC_I  = {9'b0,1'b1,2'b10,2'b00,2'b00,2'b00};
  localparam logic [17:0] E_WB_I    = {8'b0,1'b1,9'b0};
  localparam logic [17:0] E_BRANCH  = {1'b0,1'b1,7'b0,1'b1,2'b00,2'b01,2'b01,2'b00};
  localparam logic [17:0] E_JUMP    = {1'b1,13'b0,2'b10,2'b00};
  localparam logic [17:0] E_MEM_RD  = {2'b00,1'b1,1'b1,14'b0};
  localparam logic [17:0] E_MEM_WR  = {2'b00,1'b1,1'b0,1'b1,13'b0};
  localparam logic [17:0] E_WB_MEM  = {6'b0,1'b1,1'b0,1'b1,9'b0};
  localparam logic [17:0] E_HALT    = {16'b0,2'b10};
  localparam logic [17:0] E_ILL     = {16'b0,2'b01};

  wire [17:0] obs1 = {pcw1,pcc1,iord1,mrd1,mwr1,irw1,m2r1,rdst1,rw1,sa1,sb1,aop1,ps1,hlt1,ill1};
  wire [17:0] obs2 = {pcw2,pcc2,iord2,mrd2,mwr2,irw2,m2r2,rdst2,rw2,sa2,sb2,aop2,ps2,hlt2,ill2};
  wire [17:0] obs  = sel2 ? obs2 : obs1;

  multicycle_control #(.OPCODE_W(6), .CNT_W(32), .TRAP_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pcw1), .pc_write_cond(pcc1), .iord(iord1), .mem_read(mrd1),
    .mem_write(mwr1), .ir_write(irw1), .mem_to_reg(m2r1), .reg_dst(rdst1),
    .reg_write(rw1), .alu_src_a(sa1), .alu_src_b(sb1), .alu_op(aop1),
    .pc_source(ps1), .halted(hlt1), .illegal(ill1), .retired(retired)
  );

  multicycle_control #(.OPCODE_W(6), .CNT_W(4), .TRAP_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .rst_n(rst2_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pcw2), .pc_write_cond(pcc2), .iord(iord2), .mem_read(mrd2),
    .mem_write(mwr2), .ir_write(irw2), .mem_to_reg(m2r2), .reg_dst(rdst2),
    .reg_write(rw2), .alu_src_a(sa2), .alu_src_b(sb2), .alu_op(aop2),
    .pc_source(ps2), .halted(hlt2), .illegal(ill2), .retired(retired2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: compare the oldest queued expectation on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [17:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, 32'(obs), 32'(e));
    end
  end

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle (starting just after a rising edge) and queue its expectation.
  task automatic step(input logic [5:0] op, input logic rdy, input logic [17:0] e, input string tag);
    opcode = op;
    mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    exp_ret = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_ctrl", 32'(obs1), 32'd0);
    check_eq("rst_retired", retired, 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(rop(), rb(), E_IDLE, "idle");
  endtask

  task automatic do_instr(input logic [5:0] op, input int fwait, input int mwait);
    for (int i = 0; i < fwait; i++) step(rop(), 1'b0, E_FETCH_W, "fetch_wait");
    step(rop(), 1'b1, E_FETCH, "fetch");
    step(op, rb(), E_DECODE, "decode");
    case (op)
      6'h00: begin
        step(rop(), rb(), E_EXEC_R, "exec_r");
        step(rop(), rb(), E_WB_R, "wb_r");
        exp_ret++;
      end
      6'h08, 6'h09: begin
        step(rop(), rb(), E_EXEC_I, "exec_i");
        step(rop(), rb(), E_WB_I, "wb_i");
        exp_ret++;
      end
      6'h04: begin
        step(rop(), rb(), E_BRANCH, "branch");
        exp_ret++;
      end
      6'h02: begin
        step(rop(), rb(), E_JUMP, "jump");
        exp_ret++;
      end
      6'h23: begin
        step(op, rb(), E_EXEC_I, "lw_addr");
        for (int i = 0; i < mwait; i++) step(rop(), 1'b0, E_MEM_RD, "mem_rd_wait");
        step(rop(), 1'b1, E_MEM_RD, "mem_rd");
        step(rop(), rb(), E_WB_MEM, "wb_mem");
        exp_ret++;
      end
      6'h2B: begin
        step(op, rb(), E_EXEC_I, "sw_addr");
        for (int i = 0; i < mwait; i++) step(rop(), 1'b0, E_MEM_WR, "mem_wr_wait");
        step(rop(), 1'b1, E_MEM_WR, "mem_wr");
        exp_ret++;
      end
      6'h3F: for (int i = 0; i < 20; i++) step(rop(), rb(), E_HALT, "halt");
      default: for (int i = 0; i < 10; i++) step(rop(), rb(), E_ILL, "illegal");
    endcase
    check_eq("retired", retired, 32'(exp_ret));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    hold_reset();
    release_reset();
    do_instr(6'h00, 0, 0);
    do_instr(6'h23, 0, 3);
    do_instr(6'h04, 0, 0);
    do_instr(6'h02, 0, 0);
    do_instr(6'h08, 2, 0);
    do_instr(6'h09, 0, 0);
    do_instr(6'h2B, 0, 0);
    do_instr(6'h3F, 0, 0);

    hold_reset();
    release_reset();
    do_instr(6'h3E, 0, 0);

    // reset asserted while a store waits on mem_ready
    hold_reset();
    release_reset();
    do_instr(6'h08, 0, 0);
    step(rop(), 1'b1, E_FETCH, "fetch");
    step(6'h2B, rb(), E_DECODE, "decode");
    step(6'h2B, rb(), E_EXEC_I, "sw_addr");
    step(rop(), 1'b0, E_MEM_WR, "mem_wr_wait");
    check_eq("mw_held", 32'(mwr1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_mem_write", 32'(mwr1), 32'd0);
    check_eq("arst_ctrl", 32'(obs1), 32'd0);
    check_eq("arst_retired", retired, 32'd0);
    exp_ret = 0;
    release_reset();
    do_instr(6'h00, 1, 0);

    // non-trapping variant with a 4-bit counter
    rst_n = 1'b0;
    sel2 = 1'b1;
    @(negedge clk);
    check_eq("nop_rst_retired", 32'(retired2), 32'd0);
    @(posedge clk);
    #1 rst2_n = 1'b1;
    step(rop(), rb(), E_IDLE, "nop_idle");
    for (int k = 1; k <= 17; k++) begin
      step(rop(), 1'b1, E_FETCH, "nop_fetch");
      step(6'h3E, rb(), E_DECODE, "nop_decode");
      check_eq("nop_retired", 32'(retired2), 32'(k % 16));
    end
    step(rop(), 1'b1, E_FETCH, "nop_after");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Next-generation CPU control unit: a multi-cycle Moore FSM that replaces the single-cycle opcode decoder.
- Sequences fetch / decode / execute / memory / writeback for the supported MIPS subset.
- Holds in memory states until a memory-ready handshake arrives.
- Traps on illegal opcodes and on halt, and counts retired instructions.
- Sits between the instruction register opcode field and the shared datapath muxes, register file and memory port.

Parameters:
- OPCODE_W, 6, opcode field width.
- CNT_W, 32, width of the retired-instruction counter.
- TRAP_ILLEGAL, 1, 1 = unknown opcode enters ILLEGAL (sticky); 0 = unknown opcode treated as NOP.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  OPCODE_W  instruction register bits [31:26]; valid from DECODE onward.
- mem_ready  in  1  memory handshake: the access completes in a cycle where mem_ready=1.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by ALU zero (beq).
- iord  out  1  memory address select: 0 = PC, 1 = ALU out.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  register write data select: 1 = MDR.
- reg_dst  out  1  destination select: 1 = rd, 0 = rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- pc_source  out  2  00 = ALU result, 01 = ALU out register, 10 = jump target.
- halted  out  1  high in HALT state.
- illegal  out  1  high in ILLEGAL state.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Outputs are decoded from the state register only, except the pc_write / ir_write gating described under FETCH; default 0.
- rst_n low: state=IDLE, retired=0, all control outputs 0.
- IDLE: all outputs 0; next state FETCH. Guarantees one quiet cycle after reset release.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are asserted only while mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - 0x00 -> EXEC_R
  - 0x08, 0x09 -> EXEC_I
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x23, 0x2B -> MEM_ADDR
  - 0x3F -> HALT
  - any other -> ILLEGAL if TRAP_ILLEGAL, else FETCH (counted as retired).
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB_R.
- WB_R: reg_dst=1, reg_write=1 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00 -> WB_I.
- WB_I: reg_dst=0, reg_write=1 -> FETCH. addi and addiu are identical here; overflow is not checked.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1; hold until mem_ready=1 -> WB_MEM.
- WB_MEM: mem_to_reg=1, reg_dst=0, reg_write=1 -> FETCH.
- MEM_WR: mem_write=1, iord=1; hold until mem_ready=1 -> FETCH.
- Request stability: mem_read / mem_write must stay stable while waiting on mem_ready. mem_ready=1 on the first cycle of a memory state completes the access in that cycle.
- HALT: halted=1, all else 0. Terminal until rst_n.
- ILLEGAL: illegal=1, all else 0. Terminal until rst_n. Neither HALT nor ILLEGAL increments retired.
- retired: increments by 1 on the clock edge leaving the last state of each instruction. Those transitions are WB_R, WB_I, BRANCH, JUMP, WB_MEM, and MEM_WR with mem_ready=1. Wraps modulo 2^CNT_W.
- Latency in cycles with zero wait states: R-type 4, imm 4, beq 3, j 3, lw 5, sw 4. Each mem_ready=0 cycle adds 1.
- Reset mid-instruction (including during a memory wait): immediate return to IDLE; no partial writes are asserted after rst_n falls.
- opcode changes outside DECODE / MEM_ADDR are ignored.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_ADDIU, OP_J, OP_BEQ, OP_LW, OP_SW, OP_HLT
  - alu_op, alu_src_b and pc_source encodings
  - state enum
- State register + next-state logic and output decode live in this module.
- One natural sub-module: retire_counter (CNT_W, increment enable, async active-low clear).

Test Plan:
- Reset -> IDLE 1 cycle, then FETCH; add (op 0x00), mem_ready tied 1 -> ir_write+pc_write in FETCH, reg_dst=1/reg_write=1 in cycle 4, retired=1.
- lw (0x23) with mem_ready low 3 cycles in MEM_RD -> mem_read/iord held 4 cycles, WB_MEM mem_to_reg=1/reg_write=1, total 8 cycles, retired+1.
- beq (0x04) then j (0x02) -> BRANCH asserts pc_write_cond with alu_op=01, pc_source=01; JUMP asserts pc_write with pc_source=10; each takes 3 cycles; retired+2.
- sw (0x2B) then hlt (0x3F) -> mem_write once with mem_ready=1, reg_write never asserted; halted=1 stays high 20 cycles; retired unchanged after hlt.
- Opcode 0x3E with TRAP_ILLEGAL=1 -> illegal=1 sticky, all strobes 0; with TRAP_ILLEGAL=0 -> back to FETCH after DECODE, retired+1.
- rst_n pulsed low during MEM_WR wait -> mem_write drops asynchronously and retired=0; CNT_W=4 with 17 NOP-like retirements -> retired wraps to 1.
